// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus of fetch_sequencer: byte-wide instruction memory port plus
// the decode handshake. master = sequencer, slave = memory/decode environment.
interface fetch_sequencer_if;
  logic        imem_rd;
  logic [63:0] imem_addr;
  logic [7:0]  imem_rdata;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        halted;
  logic [31:0] retired;

  modport master (
    output imem_rd, imem_addr, instr, instr_pc, instr_valid, halted, retired,
    input  imem_rdata, instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_rd, imem_addr, instr, instr_pc, instr_valid, halted, retired,
    output imem_rdata, instr_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Byte-serial instruction fetch: four single-byte reads assemble a
// little-endian word that is handed to decode with a valid/ready handshake.
module fetch_sequencer #(
  parameter logic [63:0] PC_RESET = 64'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    VALID = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t      state_r;
  logic [63:0] pc_r;
  logic [1:0]  cnt_r;
  logic [31:0] instr_r;
  logic        rd_r;
  logic [63:0] addr_r;
  logic        valid_r;
  logic        halted_r;
  logic [31:0] retired_r;

  logic        transfer_s;
  logic        halt_word_s;
  logic [63:0] next_pc_s;
  logic [63:0] next_byte_addr_s;

  // Handshake decode and next-address arithmetic (all wraps modulo 2^64).
  always_comb begin
    transfer_s       = valid_r & bus.instr_ready;
    halt_word_s      = (instr_r[31:21] == 11'h7FF);
    next_byte_addr_s = pc_r + 64'(cnt_r) + 64'd1;
    if (bus.branch_taken) begin
      next_pc_s = {bus.branch_target[63:2], 2'b00};
    end else begin
      next_pc_s = pc_r + 64'd4;
    end
  end

  // Sequencer FSM; every output is a register loaded alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      pc_r      <= PC_RESET;
      cnt_r     <= 2'd0;
      instr_r   <= 32'd0;
      rd_r      <= 1'b0;
      addr_r    <= PC_RESET;
      valid_r   <= 1'b0;
      halted_r  <= 1'b0;
      retired_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= FETCH;
          cnt_r   <= 2'd0;
          rd_r    <= 1'b1;
          addr_r  <= pc_r;
        end
        FETCH: begin
          // Byte cnt-1 was read last cycle and is on imem_rdata now.
          case (cnt_r)
            2'd1:    instr_r[7:0]   <= bus.imem_rdata;
            2'd2:    instr_r[15:8]  <= bus.imem_rdata;
            2'd3:    instr_r[23:16] <= bus.imem_rdata;
            default: instr_r        <= instr_r;
          endcase
          if (cnt_r == 2'd3) begin
            state_r <= DRAIN;
            rd_r    <= 1'b0;
            addr_r  <= pc_r;
          end else begin
            cnt_r  <= cnt_r + 2'd1;
            addr_r <= next_byte_addr_s;
          end
        end
        DRAIN: begin
          instr_r[31:24] <= bus.imem_rdata;
          state_r        <= VALID;
          valid_r        <= 1'b1;
        end
        VALID: begin
          if (transfer_s) begin
            retired_r <= retired_r + 32'd1;
            valid_r   <= 1'b0;
            if (halt_word_s) begin
              state_r  <= HALT;
              halted_r <= 1'b1;
            end else begin
              pc_r    <= next_pc_s;
              addr_r  <= next_pc_s;
              rd_r    <= 1'b1;
              cnt_r   <= 2'd0;
              state_r <= FETCH;
            end
          end
        end
        HALT: begin
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= IDLE;
          cnt_r    <= 2'd0;
          rd_r     <= 1'b0;
          addr_r   <= pc_r;
          valid_r  <= 1'b0;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_rd     = rd_r;
  assign bus.imem_addr   = addr_r;
  assign bus.instr       = instr_r;
  assign bus.instr_pc    = pc_r;
  assign bus.instr_valid = valid_r;
  assign bus.halted      = halted_r;
  assign bus.retired     = retired_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed table, randomized run against a
// transaction-level model, reset and PC wrap-around cases.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic rst2_n = 1'b0;

  fetch_sequencer_if sif ();
  fetch_sequencer_if wif ();

  fetch_sequencer #(.PC_RESET(64'h0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif)
  );

  fetch_sequencer #(.PC_RESET(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (wif)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_retired;
  logic [7:0]  mem [logic [63:0]];
  logic [63:0] rd_q [$];
  logic [63:0] wq [$];

  typedef struct {
    int          stall;
    logic        bt;
    logic [63:0] tgt;
    logic [63:0] pc;
    logic [31:0] word;
  } vec_t;

  vec_t tbl [4];

  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ a[39:32] ^ 8'h3C;
  endfunction

  // Reference: the word at pc is four consecutive bytes, little-endian, addresses wrapping.
  function automatic logic [31:0] word_at(input logic [63:0] pc);
    return {mem_byte(pc + 64'd3), mem_byte(pc + 64'd2), mem_byte(pc + 64'd1), mem_byte(pc)};
  endfunction

  task automatic store_word(input logic [63:0] a, input logic [31:0] w);
    mem[a]         = w[7:0];
    mem[a + 64'd1] = w[15:8];
    mem[a + 64'd2] = w[23:16];
    mem[a + 64'd3] = w[31:24];
  endtask

  // Memory responders: byte valid the cycle after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    sif.imem_rdata <= sif.imem_rd ? mem_byte(sif.imem_addr) : 8'($urandom);
    wif.imem_rdata <= wif.imem_rd ? mem_byte(wif.imem_addr) : 8'($urandom);
  end

  always @(negedge clk) begin
    if (sif.imem_rd) rd_q.push_back(sif.imem_addr);
    if (wif.imem_rd) wq.push_back(wif.imem_addr);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_noise;
    sif.branch_taken  = 1'($urandom);
    sif.branch_target = {$urandom, $urandom};
  endtask

  // Entered one tick after the FETCH-entry edge; leaves one tick after the transfer edge.
  task automatic do_instr(input logic [63:0] pc, input logic [31:0] word, input int stall,
                          input logic bt, input logic [63:0] tgt);
    int cyc;
    rd_q.delete();
    chk("fetch_rd", 64'(sif.imem_rd), 64'd1);
    chk("fetch_addr", sif.imem_addr, pc);
    cyc = 0;
    while (!sif.instr_valid && cyc < 20) begin
      drive_noise();
      step();
      cyc++;
    end
    chk("valid_latency", 64'(cyc), 64'd5);
    if (!sif.instr_valid) return;
    chk("read_count", 64'(rd_q.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < rd_q.size()) chk("read_addr", rd_q[k], pc + 64'(k));
    end
    chk("instr", 64'(sif.instr), 64'(word));
    chk("instr_pc", sif.instr_pc, pc);
    chk("retired_pre", 64'(sif.retired), 64'(exp_retired));
    chk("valid_rd", 64'(sif.imem_rd), 64'd0);
    chk("valid_addr", sif.imem_addr, pc);
    for (int s = 0; s < stall; s++) begin
      sif.instr_ready = 1'b0;
      drive_noise();
      step();
      chk("stall_instr", 64'(sif.instr), 64'(word));
      chk("stall_pc", sif.instr_pc, pc);
      chk("stall_valid", 64'(sif.instr_valid), 64'd1);
      chk("stall_rd", 64'(sif.imem_rd), 64'd0);
      chk("stall_retired", 64'(sif.retired), 64'(exp_retired));
    end
    sif.instr_ready   = 1'b1;
    sif.branch_taken  = bt;
    sif.branch_target = tgt;
    step();
    sif.instr_ready = 1'b0;
    exp_retired = exp_retired + 32'd1;
    chk("retired_post", 64'(sif.retired), 64'(exp_retired));
    chk("valid_drop", 64'(sif.instr_valid), 64'd0);
  endtask

  task automatic chk_halted(input logic [63:0] pc);
    chk("halted", 64'(sif.halted), 64'd1);
    chk("halt_valid", 64'(sif.instr_valid), 64'd0);
    chk("halt_rd", 64'(sif.imem_rd), 64'd0);
    chk("halt_pc", sif.instr_pc, pc);
    rd_q.delete();
    sif.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_noise();
      step();
    end
    sif.instr_ready = 1'b0;
    chk("halt_no_reads", 64'(rd_q.size()), 64'd0);
    chk("halt_retired", 64'(sif.retired), 64'(exp_retired));
    chk("halt_addr", sif.imem_addr, pc);
    chk("halt_stays", 64'(sif.halted), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd"}, 64'(sif.imem_rd), 64'd0);
    chk({tag, "_valid"}, 64'(sif.instr_valid), 64'd0);
    chk({tag, "_halted"}, 64'(sif.halted), 64'd0);
    chk({tag, "_addr"}, sif.imem_addr, 64'h0);
    chk({tag, "_pc"}, sif.instr_pc, 64'h0);
    chk({tag, "_instr"}, 64'(sif.instr), 64'h0);
    chk({tag, "_retired"}, 64'(sif.retired), 64'h0);
  endtask

  initial begin
    logic [63:0] m_pc;
    logic [31:0] w;
    logic [63:0] tgt;
    logic        bt;

    store_word(64'h0,   32'h1234_5678);
    store_word(64'h4,   32'hCAFE_BABE);
    store_word(64'h100, 32'hDEAD_BEEF);
    store_word(64'h104, 32'hFFE0_0000);

    tbl[0] = '{stall: 0, bt: 1'b0, tgt: 64'h0,   pc: 64'h0,   word: 32'h1234_5678};
    tbl[1] = '{stall: 3, bt: 1'b1, tgt: 64'h103, pc: 64'h4,   word: 32'hCAFE_BABE};
    tbl[2] = '{stall: 0, bt: 1'b0, tgt: 64'h0,   pc: 64'h100, word: 32'hDEAD_BEEF};
    tbl[3] = '{stall: 2, bt: 1'b1, tgt: 64'h55,  pc: 64'h104, word: 32'hFFE0_0000};

    sif.instr_ready   = 1'b0;
    sif.branch_taken  = 1'b0;
    sif.branch_target = 64'h0;
    wif.instr_ready   = 1'b1;
    wif.branch_taken  = 1'b0;
    wif.branch_target = 64'h0;

    step();
    step();
    chk_reset_outputs("reset");
    chk("wrap_reset_addr", wif.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_reset_pc", wif.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Directed table: sequential, backpressure, branch, halt.
    rst_n = 1'b1;
    chk("idle_rd", 64'(sif.imem_rd), 64'd0);
    step();
    exp_retired = 32'd0;
    for (int i = 0; i < 4; i++) begin
      do_instr(tbl[i].pc, tbl[i].word, tbl[i].stall, tbl[i].bt, tbl[i].tgt);
    end
    chk_halted(64'h104);

    // Asynchronous reset in the middle of a fetch.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    step();
    step();
    rst_n = 1'b1;
    chk("post_reset_idle", 64'(sif.imem_rd), 64'd0);
    step();

    // Randomized run against the transaction-level model.
    exp_retired = 32'd0;
    m_pc = 64'h0;
    for (int i = 0; i < 40; i++) begin
      w  = word_at(m_pc);
      bt = 1'($urandom);
      if ($urandom_range(0, 3) == 0) tgt = {40'hFF_FFFF_FFFF, 24'hFF_FFFF} - 64'($urandom_range(0, 15));
      else tgt = {$urandom, $urandom};
      do_instr(m_pc, w, $urandom_range(0, 3), bt, tgt);
      if (w[31:21] == 11'h7FF) begin
        chk_halted(m_pc);
        break;
      end
      m_pc = bt ? {tgt[63:2], 2'b00} : m_pc + 64'd4;
    end

    // PC wrap-around from the top of the address space.
    wq.delete();
    rst2_n = 1'b1;
    for (int i = 0; i < 14; i++) step();
    chk("wrap_read_count", 64'(wq.size() >= 8), 64'd1);
    for (int k = 0; k < 8; k++) begin
      if (k < wq.size()) chk("wrap_read_addr", wq[k], 64'hFFFF_FFFF_FFFF_FFFC + 64'(k));
    end
    chk("wrap_retired", 64'(wif.retired), 64'd2);
    chk("wrap_pc", wif.instr_pc, 64'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
